aes_word_loader: RTL

//   Upstream feeder for AES_encryptor. Accepts 32-bit words on a valid/ready stream.

---
 rtl/aes_word_loader_pkg.sv | 26 ++
 rtl/aes_word_packer.sv | 47 ++++
 rtl/aes_word_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/aes_word_loader_pkg.sv
// Shared widths, FSM encoding and payload types for the AES word loader.
package aes_word_loader_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_WORDS  = AES_BLK_W / AES_WORD_W;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ISSUE,
    LD_WAIT
  } ld_state_t;

  // One beat of the input word stream.
  typedef struct packed {
    logic                  is_key;
    logic [AES_WORD_W-1:0] word;
  } ld_beat_t;

  // Block presented to the encryptor.
  typedef struct packed {
    logic [AES_BLK_W-1:0] data;
    logic [AES_BLK_W-1:0] key;
  } ld_blk_t;

endpackage

// File: rtl/aes_word_packer.sv
// Shift assembler: WORDS words of WORD_W bits into one block, first word lands in the MSBs.
module aes_word_packer
  import aes_word_loader_pkg::*;
#(
  parameter int unsigned WORDS  = AES_WORDS,
  parameter int unsigned WORD_W = AES_WORD_W,
  localparam int unsigned BLK_W  = WORDS * WORD_W,
  localparam int unsigned CNT_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [WORD_W-1:0] in_word,
  output logic [CNT_W-1:0]  cnt,
  output logic [BLK_W-1:0]  blk_c,
  output logic              done_c
);

  logic [BLK_W-1:0] asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // blk_c is the full block as it stands once the incoming word is shifted in.
  always_comb begin
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    done_c = 1'b0;
    blk_c  = {asm_q[BLK_W-WORD_W-1:0], in_word};
    if (in_vld) begin
      asm_d  = blk_c;
      done_c = (cnt_q == CNT_W'(WORDS - 1));
      cnt_d  = done_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/aes_word_loader.sv
// Feeds AES_encryptor: packs 32-bit stream words into key/plaintext blocks,
// buffers one block, issues it with a req pulse and waits for enable under a watchdog.
module aes_word_loader
  import aes_word_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_key,
  input  logic [AES_WORD_W-1:0] s_data,
  output logic [AES_BLK_W-1:0]  data,
  output logic [AES_BLK_W-1:0]  key,
  output logic                  req,
  input  logic                  enable,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PK_CNT_W = $clog2(AES_WORDS);

  ld_beat_t              beat;
  ld_state_t             state_q, state_d;
  ld_blk_t               out_q, out_d;
  logic [AES_BLK_W-1:0]  key_q, key_d;
  logic [AES_BLK_W-1:0]  pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [PK_CNT_W-1:0]   key_cnt, data_cnt;
  logic [AES_BLK_W-1:0]  key_blk_c, data_blk_c;
  logic                  key_done_c, data_done_c;
  logic                  issue_c, key_ok_c, data_ok_c, key_acc_c, data_acc_c;

  assign beat = '{is_key: s_key, word: s_data};

  // Acceptance rules keep key and data groups from interleaving and never let
  // a new key overwrite the staged key while a block is pending or in flight.
  always_comb begin
    issue_c    = (state_q == LD_IDLE) && pend_vld_q;
    key_ok_c   = !pend_vld_q && (data_cnt == '0) && (state_q == LD_IDLE);
    data_ok_c  = (key_cnt == '0) &&
                 ((data_cnt != PK_CNT_W'(AES_WORDS - 1)) || !pend_vld_q || issue_c);
    s_ready    = !rst && (beat.is_key ? key_ok_c : data_ok_c);
    key_acc_c  = s_valid && s_ready && beat.is_key;
    data_acc_c = s_valid && s_ready && !beat.is_key;
  end

  aes_word_packer #(
    .WORDS  (AES_WORDS),
    .WORD_W (AES_WORD_W)
  ) u_key_pack (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (key_acc_c),
    .in_word (beat.word),
    .cnt     (key_cnt),
    .blk_c   (key_blk_c),
    .done_c  (key_done_c)
  );

  aes_word_packer #(
    .WORDS  (AES_WORDS),
    .WORD_W (AES_WORD_W)
  ) u_data_pack (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (data_acc_c),
    .in_word (beat.word),
    .cnt     (data_cnt),
    .blk_c   (data_blk_c),
    .done_c  (data_done_c)
  );

  // Next-state and datapath: issue from pending, then wait for enable or watchdog.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    key_d      = key_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    req_d      = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;

    if (key_done_c) begin
      key_d = key_blk_c;
    end

    case (state_q)
      LD_IDLE: begin
        if (pend_vld_q) begin
          state_d    = LD_ISSUE;
          out_d      = '{data: pend_q, key: key_q};
          req_d      = 1'b1;
          pend_vld_d = 1'b0;
        end
      end
      LD_ISSUE: begin
        state_d = LD_WAIT;
        busy_d  = 1'b1;
        tmo_d   = '0;
      end
      LD_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (enable) begin
          state_d = LD_IDLE;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = LD_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase

    // A block completing on the issue edge refills pending after it drains.
    if (data_done_c) begin
      pend_d     = data_blk_c;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      out_q      <= '0;
      key_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      key_q      <= key_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  assign data        = out_q.data;
  assign key         = out_q.key;
  assign req         = req_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign blk_cnt     = cnt_q;

endmodule
